// File: rtl/bcd_pkg.sv
// Shared types for the BCD keypad entry controller.
//   NDIG    : number of BCD digits in an operand (only 3 is supported)
//   bcd_t   : one BCD digit
//   state_e : entry FSM states
package bcd_pkg;
  localparam int NDIG = 3;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    ENTRY = 1'b0,  // collecting digits, sign, clear, enter
    HOLD  = 1'b1   // operand offered to the adder, keypad locked
  } state_e;
endpackage

// File: rtl/dec_onehot_enc.sv
// One-hot decimal key encoder.
//   onehot : 10 key lines, bit k = digit k
//   digit  : BCD code of the set line (don't care when !valid)
//   valid  : exactly one line set
module dec_onehot_enc
  import bcd_pkg::*;
(
  input  logic [9:0] onehot,
  output bcd_t       digit,
  output logic       valid
);

  logic [3:0] n_set;

  always_comb begin
    digit = '0;
    n_set = '0;
    for (int k = 0; k < 10; k++) begin
      if (onehot[k]) begin
        digit = 4'(k);
        n_set = n_set + 4'd1;
      end
    end
    valid = (n_set == 4'd1);
  end

endmodule

// File: rtl/bcd_key_entry_ctrl.sv
// Keypad entry controller for one operand of the signed 3-digit BCD
// adder/subtractor. Key presses (rising edges) are encoded and shifted into
// a BCD magnitude register; enter offers the operand with valid/ready.
//   clk, rst_n        : clock, async active-low reset
//   i[9:0]            : one-hot digit keys
//   k_sgn/k_clr/k_ent : sign toggle, clear, enter keys (levels)
//   out_ready         : adder accepts operand
//   y                 : operand digits, digit 2 in the top nibble
//   sgn, cnt          : sign (1 = negative), digits entered
//   out_valid         : operand offered
//   err               : one-cycle pulse on a rejected press
// Optional: define TENS_COMP_EN to present negative operands as the
// 3-digit ten's complement of the magnitude.
module bcd_key_entry_ctrl
  import bcd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          i,
  input  logic                k_sgn,
  input  logic                k_clr,
  input  logic                k_ent,
  input  logic                out_ready,
  output logic [4*NDIG-1:0]   y,
  output logic                sgn,
  output logic [1:0]          cnt,
  output logic                out_valid,
  output logic                err
);

  state_e                state_q, state_d;
  logic [NDIG-1:0][3:0]  mag_q, mag_d;
  logic                  sgn_q, sgn_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [9:0]            i_prev_q;
  logic                  sgn_prev_q, clr_prev_q, ent_prev_q;

  bcd_t digit;
  logic digit_ok;

  dec_onehot_enc u_enc (
    .onehot (i),
    .digit  (digit),
    .valid  (digit_ok)
  );

  // A vector press is the whole key bank going from idle to non-idle, so a
  // second key added while one is held is not a new press.
  logic dig_e, sgn_e, clr_e, ent_e;
  assign dig_e = (|i) & ~(|i_prev_q);
  assign sgn_e = k_sgn & ~sgn_prev_q;
  assign clr_e = k_clr & ~clr_prev_q;
  assign ent_e = k_ent & ~ent_prev_q;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ENTRY: begin
        // Priority clr > ent > sgn > digit; lower presses are dropped.
        if (clr_e) begin
          mag_d = '0;
          sgn_d = 1'b0;
          cnt_d = '0;
        end else if (ent_e) begin
          if (cnt_q != 2'd0) state_d = HOLD;
          else               err_d   = 1'b1;
        end else if (sgn_e) begin
          sgn_d = ~sgn_q;
        end else if (dig_e) begin
          if (!digit_ok || cnt_q == 2'(NDIG)) begin
            err_d = 1'b1;
          end else begin
            mag_d = {mag_q[NDIG-2:0], digit};
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      HOLD: begin
        // Keypad is locked; only the handshake moves us on.
        if (out_ready) begin
          state_d = ENTRY;
          mag_d   = '0;
          sgn_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ENTRY;
      mag_q      <= '0;
      sgn_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      i_prev_q   <= '0;
      sgn_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      ent_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      sgn_q      <= sgn_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      // Key history tracks in every state so held keys never re-fire.
      i_prev_q   <= i;
      sgn_prev_q <= k_sgn;
      clr_prev_q <= k_clr;
      ent_prev_q <= k_ent;
    end
  end

`ifdef TENS_COMP_EN
  // (1000 - m) mod 1000 digit-wise: trailing zeros stay 0, the lowest
  // nonzero digit becomes 10-d, every digit above it becomes 9-d.
  logic [NDIG-1:0][3:0] tc;
  logic                 nz_seen;
  always_comb begin
    tc      = '0;
    nz_seen = 1'b0;
    for (int d = 0; d < NDIG; d++) begin
      if (nz_seen) begin
        tc[d] = 4'd9 - mag_q[d];
      end else if (mag_q[d] != 4'd0) begin
        tc[d]   = 4'd10 - mag_q[d];
        nz_seen = 1'b1;
      end
    end
    y = sgn_q ? tc : mag_q;
  end
`else
  assign y = mag_q;
`endif

  assign sgn       = sgn_q;
  assign cnt       = cnt_q;
  assign out_valid = (state_q == HOLD);
  assign err       = err_q;

endmodule

// File: doc/bcd_key_entry_ctrl.md
# bcd_key_entry_ctrl

Keypad entry controller for the signed 3-digit BCD adder/subtractor. Accepts one-hot decimal key lines plus sign/clear/enter keys, encodes each press to a BCD digit and shifts it into a 3-digit operand register. The operand is presented to the adder with a valid/ready handshake. One instance per operand port; the live register also drives the display.

## Interface
- NDIG, 3, number of BCD digits held; only 3 is supported.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i  in  10  one-hot decimal keys; bit k means digit k. Synchronous and already debounced.
- k_sgn  in  1  sign-toggle key, level.
- k_clr  in  1  clear key, level.
- k_ent  in  1  enter key, level.
- out_ready  in  1  adder accepts the operand.
- y  out  4*NDIG  operand BCD, digit 2 in bits [11:8].
- sgn  out  1  operand sign; 1 means negative.
- cnt  out  2  digits entered, 0..3.
- out_valid  out  1  operand offered to the adder.
- err  out  1  one-cycle pulse on a rejected press.

## Operation
- **Press detection:** a press is a rising edge of its line: the current value is nonzero or 1, and the registered previous value was zero or 0. Previous values are registered every cycle in all states.
- **Key priority** when several press edges fall in the same cycle: clr > ent > sgn > digit. Only the highest-priority press acts; the others are dropped silently.
- **States:**
  - ENTRY (reset state)
  - HOLD (operand offered)
- **ENTRY, digit press:**
  - Digit encoded by the sub-module.
  - If cnt<3: y <= {y[7:0], digit}, cnt++.
  - If cnt==3: press ignored, err pulses.
  - If the i edge is not exactly one-hot (multi-hot): no update, err pulses.
- **ENTRY, sgn press:** sgn toggles.
- **ENTRY, clr press:** y=0, sgn=0, cnt=0.
- **ENTRY, ent press:**
  - If cnt>0: go to HOLD with out_valid=1.
  - If cnt==0: err pulses, stay in ENTRY.
- **HOLD:**
  - y and sgn are frozen.
  - All keys, including clr, are ignored.
  - Key presses in HOLD do not pulse err.
  - When out_valid && out_ready at a clock edge, the transfer completes. Next cycle: out_valid=0, y=0, sgn=0, cnt=0, state ENTRY.
- **Negative zero:** y=000 with sgn=1 is transferred as-is; the adder handles it.

## Timing
- **Reset values:** y=0, sgn=0, cnt=0, out_valid=0, err=0, state ENTRY, previous-key registers=0.
- **Edge latency:**
  - i edge at edge N: y and cnt updated after edge N (visible cycle N+1).
  - err is high for exactly cycle N+1.
- **Enter latency:** k_ent edge at edge N gives out_valid=1 from cycle N+1.
- **Handshake:**
  - out_valid does not drop without a transfer.
  - y and sgn are stable while out_valid=1.
  - out_ready may be high before out_valid; the transfer then occurs on the first edge with out_valid=1.
- **Back-to-back:** a key held through the transfer is not re-accepted after the return to ENTRY; a new rising edge is required.
- **Reset mid-operation:** rst_n low at any time, including HOLD, returns all outputs to reset values immediately. No transfer is implied.

## Configuration
- **TENS_COMP_EN defined:**
  - While sgn=1, y is output as the 3-digit ten's complement (1000 − magnitude) mod 1000, computed per digit in BCD.
  - The internal magnitude register is unchanged.
  - Example: magnitude 123 with sgn=1 gives y=877; 000 gives 000.
- **TENS_COMP_EN undefined:** y is the sign-magnitude value always.

## Structure
- **Shared package (bcd_pkg):**
  - State enum {ENTRY, HOLD}.
  - BCD digit typedef (4 bits).
  - NDIG constant.
  - One-hot-to-BCD function, or the sub-module below.
- **Sub-module dec_onehot_enc:**
  - Combinational encoder: 10-bit one-hot in, 4-bit BCD out, plus a valid flag that is 1 only if exactly one bit is set.
  - Instantiated once.
- The ten's-complement logic stays inline under the macro.

## Test plan
- Reset, then press i=0x008 (3), 0x004 (2), 0x002 (1) with gaps -> y=0x321, cnt=3, no err.
- Continue from 321, press i=0x200 (9) -> y stays 0x321, err pulses one cycle.
- Press i=0x003 (multi-hot) -> no change, err pulses. Press 5, k_sgn, k_ent with out_ready=0 for 4 cycles -> out_valid held, y=0x005 and sgn=1 stable. Raise out_ready -> after one edge, out_valid=0, y=0, cnt=0.
- k_clr and k_ent rising in the same cycle with cnt=2 -> clear wins: cnt=0, no HOLD.
- Assert rst_n=0 mid-HOLD -> all outputs 0 asynchronously, no transfer counted.
- TENS_COMP_EN build: enter 123 with sgn=1 -> y=0x877; enter 0 with sgn=1 -> y=0x000.
